scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
- Upstream driver for the parameterised line decoder. Generates the decoder's enable and binary select code.
- Steps the select code through lines 0..last_idx. Each line is held enabled for a programmable dwell time, followed by a blanking gap with enable low.
- Two modes: one-shot (a single frame) or continuous (frames repeat). Used for LED/digit scanning and row strobing.

Parameters:
- IN_WIDTH, 3, width of select code a; must match the decoder's in_width.
- LINES, 8, number of decoder lines; must satisfy LINES <= 2**IN_WIDTH.
- DIV_WIDTH, 16, width of the dwell-count input.
- BLANK, 2, blanking cycles between lines (en low); 0 means no gap.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- stop  in  1  synchronous abort; priority over start.
- cont  in  1  1 = continuous frames, 0 = one frame; captured at start.
- div  in  DIV_WIDTH  dwell cycles per line; 0 is treated as 1; captured at start.
- last_idx  in  IN_WIDTH  highest line scanned; values > LINES-1 clamp to LINES-1; captured at start.
- en  out  1  decoder enable.
- a  out  IN_WIDTH  decoder select code.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- frame  out  1  1-cycle pulse on each wrap from last line to line 0 (continuous mode).
- done  out  1  1-cycle pulse on normal completion of a one-shot frame.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, en=0, a=0, busy=0, frame=0, done=0, counters=0. All outputs are registered.
- States:
  - IDLE: en=0, a=0, busy=0.
  - DWELL: en=1, a=current line, busy=1.
  - BLANK: en=0, a held at current line, busy=1.
- IDLE -> DWELL when start=1 and stop=0 at a clock edge.
  - Captures cont, div (0 -> 1) and clamped last_idx.
  - Next cycle: a=0, en=1, busy=1.
- DWELL: en stays high for exactly div_eff consecutive cycles.
  - After the last dwell cycle, go to BLANK if BLANK>0; otherwise advance immediately.
- BLANK: en stays low for exactly BLANK cycles, then advance.
- Advance rules:
  - a < last: a <= a+1, go to DWELL.
  - a == last, cont=1: a <= 0, frame=1 for one cycle (coincident with the first DWELL cycle of line 0), go to DWELL.
  - a == last, cont=0: go to IDLE, done=1 for one cycle (the first IDLE cycle), busy=0.
- Blanking also occurs after the final line of a one-shot frame, before done.
- stop=1 in DWELL or BLANK: next cycle is IDLE with en=0, a=0, busy=0. No done, no frame.
- stop=1 in IDLE blocks start.
- start while busy is ignored. div, last_idx and cont changes while busy are ignored.
- last_idx=0: the single line 0 is repeated. In continuous mode, frame pulses every div_eff+BLANK cycles.
- The dwell counter is DIV_WIDTH bits. div=all-ones gives 2**DIV_WIDTH-1 cycles with no overflow.
- Frame period = (last+1)*(div_eff+BLANK) cycles.
- en and a change on the same clock edge. a is never changed while en=1 within a line, so the decoder output stays glitch-free.

Optional Feature:
- Macro: SCAN_SKIP_EN.
- Defined:
  - Adds input line_mask [LINES-1:0]; bit=1 means skip that line. Captured at start.
  - Advance selects the next unmasked index <= last. Skipped lines get no dwell and no blank.
  - If no unmasked index remains, the sequencer applies the wrap/complete rule, then selects the lowest unmasked index (instead of line 0).
  - All lines 0..last masked at start: no DWELL; done pulses 1 cycle after acceptance in one-shot mode; continuous mode returns to IDLE with done.
- Undefined: no line_mask port; every line 0..last is scanned.

Test Plan:
- Reset mid-scan: rst_n low during DWELL of line 3 -> en=0, a=0, busy=0 immediately (asynchronous), without waiting for a clock edge; IDLE after release.
- One-shot, div=3, last_idx=2, BLANK=2:
  - en high 3 cycles for each of a=0,1,2, low 2 cycles between lines.
  - done pulses exactly 15 cycles after the first en=1 cycle; busy falls with done.
- Continuous, div=1, last_idx=7:
  - a sequence 0..7,0..; frame pulses every 24 cycles, coincident with a=0, en=1; done never asserts.
- Boundary: div=0 behaves as div=1; last_idx=7 with LINES=6 clamps to a max of 5; start while busy is ignored (frame timing unchanged).
- stop asserted in BLANK after line 1: next cycle IDLE with en=0, a=0, no done; simultaneous start+stop in IDLE remains IDLE.
- SCAN_SKIP_EN, line_mask=8'b0000_0101, last_idx=3, one-shot: only a=1 and a=3 are enabled, then done; line_mask=8'hFF -> done 1 cycle after start, en never high.

Source files
------------

// File: rtl/scan_sequencer.sv
// scan_sequencer: drives a line decoder's enable (en) and select code (a).
// It steps the select code through lines 0..last, holding each line for a
// dwell time, then a blanking gap with en low. It runs one frame (one-shot)
// or repeats frames (continuous).
// Ports:
//   clk, rst_n (async, active-low)
//   start, stop (stop wins), cont, div, last_idx  - control inputs
//   en, a, busy, frame, done                      - registered outputs
// Optional: `define SCAN_SKIP_EN adds line_mask (bit=1 skips that line).
module scan_sequencer #(
   parameter int IN_WIDTH  = 3,
   parameter int LINES     = 8,
   parameter int DIV_WIDTH = 16,
   parameter int BLANK     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 cont,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic [IN_WIDTH-1:0]  last_idx,
`ifdef SCAN_SKIP_EN
   input  logic [LINES-1:0]     line_mask,
`endif
   output logic                 en,
   output logic [IN_WIDTH-1:0]  a,
   output logic                 busy,
   output logic                 frame,
   output logic                 done
);

   typedef enum logic [1:0] {S_IDLE, S_DWELL, S_BLANK} state_t;

   localparam logic [IN_WIDTH-1:0]  MAX_IDX   = IN_WIDTH'(LINES - 1);
   localparam logic [DIV_WIDTH-1:0] BLANK_CNT = DIV_WIDTH'(BLANK);
   localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);
   localparam bit                   NO_GAP    = (BLANK == 0);

   state_t               state;
   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] div_r;
   logic [IN_WIDTH-1:0]  last_r;
   logic                 cont_r;
`ifdef SCAN_SKIP_EN
   logic [LINES-1:0]     mask_r;
`endif

   logic [IN_WIDTH-1:0]  last_c;
   logic [DIV_WIDTH-1:0] div_c;
   logic                 nxt_ok;
   logic [IN_WIDTH-1:0]  nxt_idx;
   logic [IN_WIDTH-1:0]  wrap_idx;
   logic                 first_ok;
   logic [IN_WIDTH-1:0]  first_idx;
   logic                 last_cyc;
   logic                 adv;

   always_comb begin
      last_c = (last_idx > MAX_IDX) ? MAX_IDX : last_idx;
      div_c  = (div == '0) ? ONE : div;
`ifdef SCAN_SKIP_EN
      // Descending scans leave the lowest qualifying index selected.
      nxt_ok    = 1'b0;
      nxt_idx   = '0;
      wrap_idx  = '0;
      first_ok  = 1'b0;
      first_idx = '0;
      for (int i = LINES - 1; i >= 0; i--) begin
         if (IN_WIDTH'(i) > a && IN_WIDTH'(i) <= last_r && !mask_r[i]) begin
            nxt_ok  = 1'b1;
            nxt_idx = IN_WIDTH'(i);
         end
         if (IN_WIDTH'(i) <= last_r && !mask_r[i])
            wrap_idx = IN_WIDTH'(i);
         if (IN_WIDTH'(i) <= last_c && !line_mask[i]) begin
            first_ok  = 1'b1;
            first_idx = IN_WIDTH'(i);
         end
      end
`else
      nxt_ok    = (a < last_r);
      nxt_idx   = a + IN_WIDTH'(1);
      wrap_idx  = '0;
      first_ok  = 1'b1;
      first_idx = '0;
`endif
      last_cyc = (cnt == ONE);
      // Leave the current line: end of gap, or end of dwell with no gap.
      adv = last_cyc &&
            ((state == S_BLANK) || (state == S_DWELL && NO_GAP));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         div_r  <= '0;
         last_r <= '0;
         cont_r <= 1'b0;
`ifdef SCAN_SKIP_EN
         mask_r <= '0;
`endif
         en     <= 1'b0;
         a      <= '0;
         busy   <= 1'b0;
         frame  <= 1'b0;
         done   <= 1'b0;
      end else begin
         frame <= 1'b0;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !stop) begin
                  cont_r <= cont;
                  div_r  <= div_c;
                  last_r <= last_c;
`ifdef SCAN_SKIP_EN
                  mask_r <= line_mask;
`endif
                  if (first_ok) begin
                     state <= S_DWELL;
                     en    <= 1'b1;
                     a     <= first_idx;
                     busy  <= 1'b1;
                     cnt   <= div_c;
                  end else begin
                     // Nothing to scan: complete at once.
                     done <= 1'b1;
                  end
               end
            end
            default: begin
               if (stop) begin
                  state <= S_IDLE;
                  en    <= 1'b0;
                  a     <= '0;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else if (adv) begin
                  if (nxt_ok || cont_r) begin
                     state <= S_DWELL;
                     en    <= 1'b1;
                     a     <= nxt_ok ? nxt_idx : wrap_idx;
                     frame <= !nxt_ok;
                     cnt   <= div_r;
                  end else begin
                     state <= S_IDLE;
                     en    <= 1'b0;
                     a     <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     cnt   <= '0;
                  end
               end else if (state == S_DWELL && last_cyc) begin
                  // a is held through the gap.
                  state <= S_BLANK;
                  en    <= 1'b0;
                  cnt   <= BLANK_CNT;
               end else begin
                  cnt <= cnt - ONE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed and randomized scans on two sequencers
// (LINES=8 and LINES=6) checked cycle by cycle against a timing model.
module tb_scan_sequencer;

   localparam int BL = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        cont = 1'b0;
   logic [15:0] div = '0;
   logic [2:0]  last_idx = '0;

   logic       en8, busy8, frame8, done8;
   logic [2:0] a8;
   logic       en6, busy6, frame6, done6;
   logic [2:0] a6;

   int checks = 0;
   int passed = 0;

   typedef struct {
      bit en;
      int a;
      bit busy;
      bit frame;
      bit done;
   } exp_t;

   scan_sequencer #(.IN_WIDTH(3), .LINES(8), .DIV_WIDTH(16), .BLANK(BL)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
      .div(div), .last_idx(last_idx),
      .en(en8), .a(a8), .busy(busy8), .frame(frame8), .done(done8));

   scan_sequencer #(.IN_WIDTH(3), .LINES(6), .DIV_WIDTH(16), .BLANK(BL)) dut6 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
      .div(div), .last_idx(last_idx),
      .en(en6), .a(a6), .busy(busy6), .frame(frame6), .done(done6));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
   endtask

   // Expected outputs in cycle t (t=1 is the first cycle after acceptance).
   function automatic exp_t model(input int t, input bit c, input int dv,
                                  input int lst, input int lines,
                                  input int stop_t);
      exp_t r;
      int de, nl, p, u;
      r = '{en: 0, a: 0, busy: 0, frame: 0, done: 0};
      if (stop_t > 0 && t > stop_t) return r;
      de = (dv == 0) ? 1 : dv;
      nl = ((lst > lines - 1) ? lines - 1 : lst) + 1;
      p  = de + BL;
      u  = t - 1;
      if (!c && u >= nl * p) begin
         r.done = (u == nl * p);
         return r;
      end
      r.busy  = 1;
      r.a     = (u / p) % nl;
      r.en    = (u % p) < de;
      r.frame = c && u > 0 && (u % (nl * p)) == 0;
      return r;
   endfunction

   task automatic chk_all(input string tag, input exp_t e8, input exp_t e6);
      chk({tag, "/en8"},    int'(en8),    int'(e8.en));
      chk({tag, "/a8"},     int'(a8),     e8.a);
      chk({tag, "/busy8"},  int'(busy8),  int'(e8.busy));
      chk({tag, "/frame8"}, int'(frame8), int'(e8.frame));
      chk({tag, "/done8"},  int'(done8),  int'(e8.done));
      chk({tag, "/en6"},    int'(en6),    int'(e6.en));
      chk({tag, "/a6"},     int'(a6),     e6.a);
      chk({tag, "/busy6"},  int'(busy6),  int'(e6.busy));
      chk({tag, "/frame6"}, int'(frame6), int'(e6.frame));
      chk({tag, "/done6"},  int'(done6),  int'(e6.done));
   endtask

   // Accept a scan, then check ncyc cycles; optional stop and noise.
   task automatic run(input string tag, input bit c, input int dv,
                      input int lst, input int ncyc, input int stop_t,
                      input bit noise);
      exp_t e8, e6;
      start    = 1'b1;
      stop     = 1'b0;
      cont     = c;
      div      = 16'(dv);
      last_idx = 3'(lst);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int t = 1; t <= ncyc; t++) begin
         e8 = model(t, c, dv, lst, 8, stop_t);
         e6 = model(t, c, dv, lst, 6, stop_t);
         chk_all(tag, e8, e6);
         if (t == ncyc) break;
         stop = (t == stop_t);
         if (noise) begin
            // start only while both are busy, so it must be ignored
            start    = e8.busy && e6.busy && $urandom_range(0, 3) == 0;
            cont     = 1'($urandom);
            div      = 16'($urandom_range(0, 7));
            last_idx = 3'($urandom);
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   exp_t z;

   initial begin
      z = '{en: 0, a: 0, busy: 0, frame: 0, done: 0};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", z, z);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all("post_reset", z, z);

      // one-shot div=3 last=2: done 15 cycles after first en
      run("oneshot", 1'b0, 3, 2, 19, 0, 1'b0);

      // continuous div=1 last=7: frame every 24 cycles
      run("cont", 1'b1, 1, 7, 60, 55, 1'b0);

      // div=0 behaves as 1
      run("div0", 1'b0, 0, 3, 16, 0, 1'b0);

      // last_idx=7 clamps on LINES=6; start while busy ignored
      run("clamp", 1'b1, 2, 7, 70, 65, 1'b1);

      // stop in blank after line 1 (div=2: blank at t=7,8)
      run("stop_blank", 1'b0, 2, 3, 14, 7, 1'b0);

      // start+stop together in IDLE
      start = 1'b1;
      stop  = 1'b1;
      div   = 16'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      chk_all("start_stop_1", z, z);
      @(posedge clk);
      #1;
      chk_all("start_stop_2", z, z);

      // randomized scans
      for (int k = 0; k < 8; k++) begin
         bit c;
         int dv, lst, nc;
         c   = 1'($urandom);
         dv  = $urandom_range(0, 5);
         lst = $urandom_range(0, 7);
         if (c) begin
            nc = $urandom_range(20, 90);
            run("rand_cont", c, dv, lst, nc, nc - 3, 1'b1);
         end else begin
            nc = (lst + 1) * (((dv == 0) ? 1 : dv) + BL) + 3;
            run("rand_one", c, dv, lst, nc, 0, 1'b1);
         end
      end

      // async reset mid-scan at dwell of line 3 (div=3: t=16)
      run("pre_rst", 1'b1, 3, 7, 16, 0, 1'b0);
      chk("pre_rst_a3", int'(a8), 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_en", int'(en8), 0);
      chk("rst_async_a", int'(a8), 0);
      chk("rst_async_busy", int'(busy8), 0);
      chk("rst_async_busy6", int'(busy6), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all("rst_idle", z, z);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
